// File: rtl/div_sequencer_pkg.sv
// Shared encodings and constants for the iterative divider and its datapath.
package div_sequencer_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 5;

  localparam logic [DIV_DATA_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; only signed requests treat the top bit as a sign.
  function automatic logic [DIV_DATA_W-1:0] abs_op(input logic [DIV_DATA_W-1:0] v,
                                                   input logic                  is_signed);
    return (is_signed && v[DIV_DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter_dp.sv
// Restoring radix-2 division datapath: operand latch, one quotient bit per step,
// and a registered sign fix that produces the held results.
module div_iter_dp
  import div_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  logic                  signed_i,
  input  logic [DIV_DATA_W-1:0] dividend_i,
  input  logic [DIV_DATA_W-1:0] divisor_i,
  output logic                  div_zero_o,
  output logic [DIV_DATA_W-1:0] div_result_o,
  output logic [DIV_DATA_W-1:0] mod_result_o
);

  localparam int W = DIV_DATA_W;

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic         q_neg_q, q_neg_d;
  logic         r_neg_q, r_neg_d;
  logic [W-1:0] div_res_q, div_res_d;
  logic [W-1:0] mod_res_q, mod_res_d;

  logic [W:0]   rem_sh;
  logic         trial_ok;
  logic [W-1:0] trial_diff;

  assign div_zero_o = (divisor_i == '0);

  // rem < divisor always holds, so a successful trial difference fits in W bits.
  assign rem_sh     = {rem_q, quo_q[W-1]};
  assign trial_ok   = (rem_sh >= {1'b0, dvs_q});
  assign trial_diff = rem_sh[W-1:0] - dvs_q;

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div_res_d = div_res_q;
    mod_res_d = mod_res_q;
    if (load_i) begin
      dvs_d = abs_op(divisor_i, signed_i);
      if (div_zero_o) begin
        // Preload the divide-by-zero answer so the normal fix step publishes it.
        quo_d   = DIV_BY_ZERO_Q;
        rem_d   = dividend_i;
        q_neg_d = 1'b0;
        r_neg_d = 1'b0;
      end else begin
        quo_d   = abs_op(dividend_i, signed_i);
        rem_d   = '0;
        q_neg_d = signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
        r_neg_d = signed_i & dividend_i[W-1];
      end
    end else if (step_i) begin
      rem_d = trial_ok ? trial_diff : rem_sh[W-1:0];
      quo_d = {quo_q[W-2:0], trial_ok};
    end else if (fix_i) begin
      div_res_d = q_neg_q ? -quo_q : quo_q;
      mod_res_d = r_neg_q ? -rem_q : rem_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div_res_q <= '0;
      mod_res_q <= '0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div_res_q <= div_res_d;
      mod_res_q <= mod_res_d;
    end
  end

  assign div_result_o = div_res_q;
  assign mod_result_o = mod_res_q;

endmodule

// File: rtl/div_sequencer.sv
// Iterative 32-bit divider top: handshake FSM and iteration counter driving div_iter_dp.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DIV_W = DIV_DATA_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [DIV_W-1:0] req_dividend,
  input  logic [DIV_W-1:0] req_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] div_result,
  output logic [DIV_W-1:0] mod_result,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  logic accept;
  logic dp_load;
  logic dp_step;
  logic dp_fix;
  logic div_zero;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // last_q marks that all iterations are done and the next CALC cycle is the sign fix.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            state_d = DIV_CALC;
            cnt_d   = '0;
            // A zero divisor skips the iterations and goes directly to the fix cycle.
            last_d  = div_zero;
          end
        end
        DIV_CALC: begin
          if (last_q) begin
            state_d = DIV_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_W - 1)) last_d = 1'b1;
          end
        end
        DIV_DONE: begin
          if (out_ready) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == DIV_IDLE) & ~flush;
    accept    = req_valid & req_ready;
    dp_load   = accept;
    dp_step   = (state_q == DIV_CALC) & ~last_q & ~flush;
    dp_fix    = (state_q == DIV_CALC) &  last_q & ~flush;
    out_valid = (state_q == DIV_DONE);
    busy      = (state_q != DIV_IDLE);
  end

  div_iter_dp u_dp (
    .clk          (clk),
    .resetn       (resetn),
    .load_i       (dp_load),
    .step_i       (dp_step),
    .fix_i        (dp_fix),
    .signed_i     (req_signed),
    .dividend_i   (req_dividend),
    .divisor_i    (req_divisor),
    .div_zero_o   (div_zero),
    .div_result_o (div_result),
    .mod_result_o (mod_result)
  );

endmodule
